// File: rtl/bcd_pkg.sv
// bcd_pkg: shared definitions for the serial BCD subtractor.
//   state_t : controller states (IDLE, RUN)
//   BCD_W   : width of one packed BCD digit
//   RADIX   : decimal radix used for the borrow correction
package bcd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int BCD_W = 4;
  localparam int RADIX = 10;

endpackage

// File: rtl/bcd_digit_sub.sv
// bcd_digit_sub: combinational single-digit BCD subtractor.
// Computes a - b - bin. If the result is negative, the radix is added back
// and a borrow is raised.
//   a, b    : input digits (4 bits each)
//   bin     : borrow in
//   d       : result digit
//   bout    : borrow out
//   invalid : a or b is above 9 (present only with BCD_SUB_DIGIT_CHECK_EN)
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             bin,
  output logic [BCD_W-1:0] d,
  output logic             bout
`ifdef BCD_SUB_DIGIT_CHECK_EN
  ,
  output logic             invalid
`endif
);

  // Two guard bits keep the full range of -16..15 representable.
  localparam logic signed [BCD_W+1:0] RADIX_S = (BCD_W+2)'(RADIX);

  logic signed [BCD_W+1:0] diff_raw;
  logic signed [BCD_W+1:0] diff_adj;

  always_comb begin
    diff_raw = $signed({2'b00, a}) - $signed({2'b00, b})
             - $signed({{(BCD_W+1){1'b0}}, bin});
    if (diff_raw < 0) begin
      diff_adj = diff_raw + RADIX_S;
      bout     = 1'b1;
    end else begin
      diff_adj = diff_raw;
      bout     = 1'b0;
    end
    d = diff_adj[BCD_W-1:0];
  end

`ifdef BCD_SUB_DIGIT_CHECK_EN
  assign invalid = (a > BCD_W'(RADIX-1)) || (b > BCD_W'(RADIX-1));
`endif

endmodule

// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor: digit-serial packed-BCD subtractor.
// Diff = A - B - Bin modulo 10^DIGITS, with one digit processed per clock,
// least-significant digit first. Results are produced DIGITS cycles after
// the start is accepted. A new start can be accepted on the edge right
// after the done edge.
// Optional feature: define BCD_SUB_DIGIT_CHECK_EN to add the err output,
// which flags operands containing digits above 9.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request an operation (sampled only while idle)
//   A, B  : packed BCD minuend / subtrahend, digit 0 in bits [3:0]
//   Bin   : borrow in
//   Diff  : packed BCD result (ten's complement when negative)
//   Bout  : borrow out, set when A < B + Bin
//   busy  : operation in progress
//   done  : one-cycle pulse when Diff/Bout are updated
//   err   : invalid-digit flag (only with BCD_SUB_DIGIT_CHECK_EN)
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BCD_W*DIGITS-1:0] A,
  input  logic [BCD_W*DIGITS-1:0] B,
  input  logic                    Bin,
  output logic [BCD_W*DIGITS-1:0] Diff,
  output logic                    Bout,
  output logic                    busy,
  output logic                    done
`ifdef BCD_SUB_DIGIT_CHECK_EN
  ,
  output logic                    err
`endif
);

  localparam int W     = BCD_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t           state;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     acc_q;
  logic [IDX_W-1:0] idx_q;
  logic             borrow_q;

  logic [BCD_W-1:0] a_dig;
  logic [BCD_W-1:0] b_dig;
  logic [BCD_W-1:0] d_dig;
  logic             bout_dig;
  logic [W-1:0]     acc_next;

`ifdef BCD_SUB_DIGIT_CHECK_EN
  logic             dig_invalid;
  logic             flag_q;
`endif

  // The current digit is selected from the captured operands by the index.
  always_comb begin
    a_dig = a_q[idx_q*BCD_W +: BCD_W];
    b_dig = b_q[idx_q*BCD_W +: BCD_W];
  end

  bcd_digit_sub u_digit (
    .a       (a_dig),
    .b       (b_dig),
    .bin     (borrow_q),
    .d       (d_dig),
    .bout    (bout_dig)
`ifdef BCD_SUB_DIGIT_CHECK_EN
    ,
    .invalid (dig_invalid)
`endif
  );

  // Accumulated result with the digit computed this cycle already inserted,
  // so the last edge can publish the complete result directly.
  always_comb begin
    acc_next = acc_q;
    acc_next[idx_q*BCD_W +: BCD_W] = d_dig;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      Diff     <= '0;
      Bout     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef BCD_SUB_DIGIT_CHECK_EN
      flag_q   <= 1'b0;
      err      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q      <= A;
            b_q      <= B;
            borrow_q <= Bin;
            acc_q    <= '0;
            idx_q    <= '0;
            busy     <= 1'b1;
            state    <= RUN;
`ifdef BCD_SUB_DIGIT_CHECK_EN
            flag_q   <= 1'b0;
`endif
          end
        end
        RUN: begin
          borrow_q <= bout_dig;
          acc_q    <= acc_next;
`ifdef BCD_SUB_DIGIT_CHECK_EN
          flag_q   <= flag_q | dig_invalid;
`endif
          if (idx_q == LAST_IDX) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
`ifdef BCD_SUB_DIGIT_CHECK_EN
            // An invalid digit anywhere in the operands suppresses the result.
            err <= flag_q | dig_invalid;
            if (flag_q | dig_invalid) begin
              Diff <= '0;
              Bout <= 1'b0;
            end else begin
              Diff <= acc_next;
              Bout <= bout_dig;
            end
`else
            Diff <= acc_next;
            Bout <= bout_dig;
`endif
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// tb_bcd_serial_subtractor: self-checking bench for bcd_serial_subtractor
// (DIGITS=2). Directed vector table, hand-written timing/reset/back-to-back
// sequences and randomized operations checked against a decimal model.
module tb_bcd_serial_subtractor;

  localparam int D = 2;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic [W-1:0] Diff;
  logic         Bout;
  logic         busy;
  logic         done;
`ifdef BCD_SUB_DIGIT_CHECK_EN
  logic         err;
`endif

  bcd_serial_subtractor #(.DIGITS(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .Diff  (Diff),
    .Bout  (Bout),
    .busy  (busy),
    .done  (done)
`ifdef BCD_SUB_DIGIT_CHECK_EN
    ,
    .err   (err)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int ndone   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Decimal reference model: convert to integers, subtract, wrap modulo 10^D.
  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r;
    int t = v;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       output logic [W-1:0] d, output logic bo);
    int t;
    t  = bcd2int(a) - bcd2int(b) - int'(bin);
    bo = (t < 0);
    if (t < 0) t = t + 10 ** D;
    d  = int2bcd(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (done) ndone++;
  endtask

  // Issue one operation and wait (bounded) for done. cyc = edges after E0.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        output logic [W-1:0] d, output logic bo, output int cyc);
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    d  = Diff;
    bo = Bout;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [W-1:0] d, ed, ra, rb;
    logic         bo, ebo, rbin;
    int           cyc;

    vecs[0] = '{8'h08, 8'h03, 1'b0, 8'h05, 1'b0};
    vecs[1] = '{8'h10, 8'h01, 1'b0, 8'h09, 1'b0};
    vecs[2] = '{8'h32, 8'h16, 1'b0, 8'h16, 1'b0};
    vecs[3] = '{8'h40, 8'h15, 1'b1, 8'h24, 1'b0};
    vecs[4] = '{8'h99, 8'h99, 1'b1, 8'h99, 1'b1};
    vecs[5] = '{8'h00, 8'h01, 1'b0, 8'h99, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h99, 1'b1};
    vecs[7] = '{8'h99, 8'h00, 1'b0, 8'h99, 1'b0};

    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_diff", 32'(Diff), 32'h0);
    chk("reset_bout", 32'(Bout), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    rst = 1'b0;

    // Detailed timing of 08 - 03
    @(negedge clk);
    A = 8'h08; B = 8'h03; Bin = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    chk("t_e0_busy", 32'(busy), 32'h1);
    chk("t_e0_done", 32'(done), 32'h0);
    tick();
    chk("t_e1_busy", 32'(busy), 32'h1);
    chk("t_e1_done", 32'(done), 32'h0);
    tick();
    chk("t_e2_done", 32'(done), 32'h1);
    chk("t_e2_busy", 32'(busy), 32'h0);
    chk("t_e2_diff", 32'(Diff), 32'h05);
    chk("t_e2_bout", 32'(Bout), 32'h0);
    tick();
    chk("t_e3_done", 32'(done), 32'h0);
    chk("t_e3_hold", 32'(Diff), 32'h05);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, d, bo, cyc);
      chk($sformatf("vec%0d_lat", i), 32'(cyc), 32'(D));
      chk($sformatf("vec%0d_diff", i), 32'(d), 32'(vecs[i].diff));
      chk($sformatf("vec%0d_bout", i), 32'(bo), 32'(vecs[i].bout));
`ifdef BCD_SUB_DIGIT_CHECK_EN
      chk($sformatf("vec%0d_err", i), 32'(err), 32'h0);
`endif
    end

    // start held high, operands changing mid-operation
    @(negedge clk);
    A = 8'h08; B = 8'h03; Bin = 1'b0; start = 1'b1;
    ndone = 0;
    tick(); A = 8'h77; B = 8'h11;            // E0
    tick(); A = 8'h42;                        // E1
    tick();                                   // E2
    chk("b2b_done1", 32'(done), 32'h1);
    chk("b2b_diff1", 32'(Diff), 32'h05);
    A = 8'h77;
    tick();                                   // E3: new acceptance
    chk("b2b_busy_e3", 32'(busy), 32'h1);
    A = 8'h00; B = 8'h99;
    tick();                                   // E4
    tick();                                   // E5
    chk("b2b_done2", 32'(done), 32'h1);
    chk("b2b_diff2", 32'(Diff), 32'h66);
    start = 1'b0;
    tick();
    chk("b2b_idle", 32'(busy), 32'h0);
    chk("b2b_ndone", 32'(ndone), 32'h2);

    // Reset in the middle of 50 - 25
    @(negedge clk);
    A = 8'h50; B = 8'h25; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;                       // E0
    start = 1'b0; rst = 1'b1;
    @(posedge clk); #1;                       // E1
    rst = 1'b0;
    chk("rst_diff", 32'(Diff), 32'h0);
    chk("rst_bout", 32'(Bout), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    ndone = 0;
    repeat (4) tick();
    chk("rst_nodone", 32'(ndone), 32'h0);
    run_op(8'h50, 8'h25, 1'b0, d, bo, cyc);
    chk("rst_fresh_diff", 32'(d), 32'h25);
    chk("rst_fresh_bout", 32'(bo), 32'h0);

    // Randomized operations against the decimal model
    for (int i = 0; i < 40; i++) begin
      ra   = int2bcd(int'($urandom_range(0, 10 ** D - 1)));
      rb   = int2bcd(int'($urandom_range(0, 10 ** D - 1)));
      rbin = 1'($urandom_range(0, 1));
      model(ra, rb, rbin, ed, ebo);
      run_op(ra, rb, rbin, d, bo, cyc);
      chk($sformatf("rnd%0d_%0h-%0h-%0d_diff", i, ra, rb, rbin), 32'(d), 32'(ed));
      chk($sformatf("rnd%0d_bout", i), 32'(bo), 32'(ebo));
      chk($sformatf("rnd%0d_lat", i), 32'(cyc), 32'(D));
    end

`ifdef BCD_SUB_DIGIT_CHECK_EN
    run_op(8'h1A, 8'h01, 1'b0, d, bo, cyc);
    chk("err_set", 32'(err), 32'h1);
    chk("err_diff", 32'(d), 32'h00);
    chk("err_bout", 32'(bo), 32'h0);
    run_op(8'h12, 8'h01, 1'b0, d, bo, cyc);
    chk("err_clear", 32'(err), 32'h0);
    chk("err_next_diff", 32'(d), 32'h11);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bcd_serial_subtractor.md
BCD_SERIAL_SUBTRACTOR -- requirements
Module: bcd_serial_subtractor

Interface
REQ-001 SHALL have parameter DIGITS, default 2: number of packed BCD digits per operand (legal range 1..8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 SHALL have port A, input, 4*DIGITS bits: packed BCD minuend, digit 0 in A[3:0].
REQ-006 SHALL have port B, input, 4*DIGITS bits: packed BCD subtrahend.
REQ-007 SHALL have port Bin, input, 1 bit: borrow in.
REQ-008 SHALL have port Diff, output, 4*DIGITS bits: packed BCD result, A - B - Bin modulo 10^DIGITS.
REQ-009 SHALL have port Bout, output, 1 bit: borrow out; 1 when A < B + Bin.
REQ-010 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse marking Diff/Bout valid.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and RUN.
REQ-013 SHALL, at edge E0 with state IDLE and start=1, capture A, B and Bin into internal registers, enter RUN, set the digit index to 0 and assert busy.
REQ-014 SHALL ignore start, A, B and Bin while in RUN; captured operands are unaffected.
REQ-015 SHALL process one digit per edge, LSD first, on edges E1..E_DIGITS: d = a_i - b_i - borrow (5-bit signed); if d<0 then d+=10 and borrow=1, else borrow=0; store d[3:0] as digit i.
REQ-016 SHALL seed the borrow chain with the captured Bin.
REQ-017 SHALL, at edge E_DIGITS, update Diff and Bout together, set done=1, clear busy and return to IDLE.
REQ-018 SHALL clear done at the next edge; done is never high for more than one cycle.
REQ-019 SHALL hold Diff and Bout stable between done pulses.
REQ-020 SHALL accept a new start at the first edge after the done edge, E_DIGITS+1, giving a back-to-back throughput of one result per DIGITS+1 cycles.
REQ-021 SHALL, on a negative result, present the ten's complement in Diff: for example 00 - 01 gives Diff=99, Bout=1.
REQ-022 SHALL, for non-BCD input digits (values 10..15) with the check disabled, still apply REQ-015 verbatim; the result is deterministic but not meaningful.

Reset
REQ-023 SHALL, when rst=1 at any edge, including mid-operation, force state IDLE, Diff=0, Bout=0, busy=0, done=0 and clear the internal operand, index and borrow registers; rst has priority over start.
REQ-024 SHALL produce no done pulse for an operation aborted by reset.

Configuration
REQ-025 SHALL honour macro BCD_SUB_DIGIT_CHECK_EN.
- When defined: add output err (1 bit, reset 0). Any captured digit of A or B greater than 9 sets a sticky invalid flag during RUN. At the done edge err=flag and, if the flag is set, Diff=0 and Bout=0. err holds until the next done or reset.
- When undefined: no err port and no check logic.

Structure
REQ-026 SHALL place the FSM state enumeration (IDLE, RUN), the BCD digit width constant (4) and the radix constant (10) in a shared package, bcd_pkg.
REQ-027 SHALL instantiate one sub-module, bcd_digit_sub: a combinational single-digit subtractor with inputs a, b, bin and outputs d, bout, plus digit-invalid when the macro is enabled.

Verification (DIGITS=2, Bin=0 unless stated)
REQ-028 SHALL cover: A=08, B=03, start at E0 -> busy high E0..E1; done=1 after E2 with Diff=05, Bout=0; done=0 after E3.
REQ-029 SHALL cover: A=10, B=01 -> Diff=09, Bout=0 (borrow across digits); A=32, B=16 -> Diff=16.
REQ-030 SHALL cover: A=40, B=15, Bin=1 -> Diff=24, Bout=0; A=99, B=99, Bin=1 -> Diff=99, Bout=1.
REQ-031 SHALL cover: start held high through RUN, with A and B changed mid-operation -> exactly one done per accepted start; results reflect the captured operands; next acceptance at E3.
REQ-032 SHALL cover: rst asserted at E1 of A=50, B=25 -> no done; all outputs 0; a fresh start afterwards gives a correct result.
REQ-033 SHALL cover, with BCD_SUB_DIGIT_CHECK_EN defined: A=1A, B=01 -> err=1, Diff=00, Bout=0 at done; the next valid operation clears err.
